// File: rtl/uart_mem_loader.sv
// UART program-image loader: receives a framed, checksummed image over 8N1 UART,
// writes it into the core's program memory and releases core reset on success.
module uart_mem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              core_resetn,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // ---- stage p0/p1: rx synchroniser, p2: previous sample for edge detect ----
    logic rx_p0, rx_p1, rx_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    // ---- UART byte receiver ----
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t        rx_state, rx_state_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       rx_sr, rx_sr_next;
    logic             byte_vld, byte_vld_next;
    logic             frame_err, frame_err_next;

    always_comb begin
        rx_state_next  = rx_state;
        bit_cnt_next   = bit_cnt;
        bit_idx_next   = bit_idx;
        rx_sr_next     = rx_sr;
        byte_vld_next  = 1'b0;
        frame_err_next = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_p2 && !rx_p1) begin
                    bit_cnt_next  = '0;
                    rx_state_next = R_START;
                end
            end
            R_START: begin
                if (bit_cnt == HALF_M1) begin
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    // still high at mid-start means it was only a glitch
                    rx_state_next = rx_p1 ? R_IDLE : R_DATA;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            R_DATA: begin
                if (bit_cnt == FULL_M1) begin
                    bit_cnt_next = '0;
                    rx_sr_next   = {rx_p1, rx_sr[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) rx_state_next = R_STOP;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            R_STOP: begin
                if (bit_cnt == FULL_M1) begin
                    bit_cnt_next   = '0;
                    byte_vld_next  = rx_p1;
                    frame_err_next = !rx_p1;
                    rx_state_next  = R_IDLE;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            default: rx_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state  <= R_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            rx_sr     <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_state_next;
            bit_cnt   <= bit_cnt_next;
            bit_idx   <= bit_idx_next;
            rx_sr     <= rx_sr_next;
            byte_vld  <= byte_vld_next;
            frame_err <= frame_err_next;
        end
    end

    // ---- load FSM: frame parsing, word assembly, memory write ----
    typedef enum logic [2:0] {L_IDLE, L_CNT_LO, L_CNT_HI, L_DATA, L_CSUM, L_RUN} ld_state_t;

    ld_state_t         ld_state, ld_state_next;
    logic [15:0]       n_words, n_words_next;
    logic [ADDR_W:0]   word_idx, word_idx_next;
    logic [1:0]        byte_idx, byte_idx_next;
    logic [23:0]       word_sr, word_sr_next;
    logic [7:0]        csum, csum_next;
    logic              we_next, done_next, err_next;
    logic [ADDR_W-1:0] waddr_next;
    logic [31:0]       wdata_next;
    logic [15:0]       n_cand;
    logic              sync_seen;

    assign n_cand    = {rx_sr, n_words[7:0]};
    assign sync_seen = byte_vld && (rx_sr == SYNC_BYTE);

    always_comb begin
        ld_state_next = ld_state;
        n_words_next  = n_words;
        word_idx_next = word_idx;
        byte_idx_next = byte_idx;
        word_sr_next  = word_sr;
        csum_next     = csum;
        we_next       = 1'b0;
        waddr_next    = waddr;
        wdata_next    = wdata;
        done_next     = done;
        err_next      = err;
        if (frame_err && ld_state != L_IDLE && ld_state != L_RUN) begin
            err_next      = 1'b1;
            ld_state_next = L_IDLE;
        end else if (byte_vld) begin
            case (ld_state)
                L_IDLE, L_RUN: begin
                    if (sync_seen) begin
                        done_next     = 1'b0;
                        err_next      = 1'b0;
                        word_idx_next = '0;
                        byte_idx_next = '0;
                        csum_next     = '0;
                        ld_state_next = L_CNT_LO;
                    end
                end
                L_CNT_LO: begin
                    n_words_next  = {n_words[15:8], rx_sr};
                    ld_state_next = L_CNT_HI;
                end
                L_CNT_HI: begin
                    n_words_next = n_cand;
                    if (n_cand == 16'd0 || {16'd0, n_cand} > 32'(DEPTH)) begin
                        err_next      = 1'b1;
                        ld_state_next = L_IDLE;
                    end else begin
                        ld_state_next = L_DATA;
                    end
                end
                L_DATA: begin
                    csum_next     = csum_add(csum, rx_sr);
                    word_sr_next  = {rx_sr, word_sr[23:8]};
                    byte_idx_next = byte_idx + 1'b1;
                    if (byte_idx == 2'd3) begin
                        we_next       = 1'b1;
                        waddr_next    = word_idx[ADDR_W-1:0];
                        wdata_next    = {rx_sr, word_sr};
                        word_idx_next = word_idx + 1'b1;
                        if (32'(word_idx) + 32'd1 == 32'(n_words)) ld_state_next = L_CSUM;
                    end
                end
                L_CSUM: begin
                    if (rx_sr == csum) begin
                        done_next     = 1'b1;
                        ld_state_next = L_RUN;
                    end else begin
                        err_next      = 1'b1;
                        ld_state_next = L_IDLE;
                    end
                end
                default: ld_state_next = L_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_state    <= L_IDLE;
            word_idx    <= '0;
            byte_idx    <= '0;
            we          <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            core_resetn <= 1'b0;
        end else begin
            ld_state    <= ld_state_next;
            word_idx    <= word_idx_next;
            byte_idx    <= byte_idx_next;
            we          <= we_next;
            waddr       <= waddr_next;
            wdata       <= wdata_next;
            done        <= done_next;
            err         <= err_next;
            core_resetn <= (ld_state_next == L_RUN);
        end
    end

    // Frame payload registers are always re-initialised by the sync byte before use.
    always_ff @(posedge clk) begin
        n_words <= n_words_next;
        word_sr <= word_sr_next;
        csum    <= csum_next;
    end

endmodule
